char_sequencer: RTL
===================

# char_sequencer

Character/name sequencer that sits directly upstream of the name-length lookup. It holds the current name index and character position, presents the name index to the lookup, and takes back that name's last-character index (`limit`). On each step it advances the character position, wraps to 0 after the last character, and moves on to the next name. Its outputs feed the glyph/display path, which renders character `char_idx` of name `name`.

## Interface
Parameters:
- `PRESCALE`, default 1000: clk cycles per internal step. Used only with `CHAR_SEQ_PRESCALE_EN`; legal range 2..65535.

Ports:
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `ena`  in  1  global enable; 0 freezes all state, including the prescaler.
- `step`  in  1  one-cycle advance strobe. Used when the prescaler is compiled out; ignored otherwise.
- `hold`  in  1  pause. Blocks advance and freezes the prescaler count.
- `load`  in  1  synchronous load of `name_sel`.
- `name_sel`  in  3  name index taken on `load`.
- `limit`  in  5  last valid char index of the current `name`, from the lookup. Combinational from the `name` output.
- `name`  out  3  current name index, registered.
- `char_idx`  out  5  current character index, registered.
- `char_strobe`  out  1  one-cycle pulse: `char_idx` or `name` changed this cycle.
- `name_done`  out  1  one-cycle pulse: wrap from the last character occurred this cycle.

## Operation
- Reset values: `name`=0, `char_idx`=0, `char_strobe`=0, `name_done`=0, prescaler count=0.
- Advance event `adv` = `ena` & !`hold` & !`load` & tick.
  - tick = `step` when the prescaler is compiled out.
  - tick = prescaler terminal count when it is compiled in.
- Priority, highest first: reset, `load`, `!ena`, `hold`, `adv`.
- `load` (when `ena`=1):
  - `name`<=`name_sel`, `char_idx`<=0, prescaler count<=0.
  - `char_strobe`<=1, `name_done`<=0.
  - `load` with `ena`=0 is ignored.
- `adv` when `char_idx` < `limit`: `char_idx`<=`char_idx`+1 and `char_strobe`<=1.
- `adv` when `char_idx` >= `limit` (wrap):
  - `char_idx`<=0 and `name`<=`name`+1, mod 8 (7 wraps to 0).
  - `char_strobe`<=1 and `name_done`<=1.
  - Using >= makes the block safe if `limit` drops below `char_idx`.
- No `adv` and no `load`: `char_strobe`=0, `name_done`=0.
- `limit`=0: every `adv` wraps, so `name_done` pulses on every step.
- `hold` or `!ena` arriving together with a tick: the tick is dropped, not queued.
- Arithmetic is 5-bit unsigned; `char_idx` never exceeds 31 and never exceeds `limit` except transiently after a `limit` change.

## Timing
- Latency: `step` high in cycle N gives new `char_idx`/`name` and pulses in cycle N+1.
- `limit` must settle within the same cycle after `name` changes. There is no combinational loop because `name` is a flop.
- Prescaler:
  - Counts 0..`PRESCALE`-1 while `ena` & !`hold`.
  - The terminal count yields one tick, then the count returns to 0.
  - First tick after reset or `load` arrives `PRESCALE` cycles later.
- Reset mid-operation clears everything asynchronously; the first advance can occur on the first edge after deassertion.
- Back-to-back `step` every cycle is legal: one advance per cycle.

## Configuration
- `CHAR_SEQ_PRESCALE_EN` defined: internal prescaler instantiated; tick comes from the prescaler; `step` is unused.
- Not defined: no prescaler logic; tick = `step`; `PRESCALE` is unused.

## Structure
- Shared package:
  - `NAME_W`=3, `CHAR_W`=5, `NUM_NAMES`=8.
  - Name/char index typedefs used by this block, the length lookup and the glyph path.
- One sub-module: `step_prescaler` (count register + terminal-count tick, with enable and clear), instantiated only under `CHAR_SEQ_PRESCALE_EN`.
- The length lookup is instantiated at top level beside this block, not inside it.

## Test plan
- Reset, then no step for 10 cycles -> `name`=0, `char_idx`=0, no pulses.
- `limit`=11, 12 `step` pulses -> `char_idx` 1..11 then 0; `name` 0->1; `name_done` exactly once, in the cycle after the 12th step.
- `load` with `name_sel`=7 and `limit`=11, then 12 steps -> `name` wraps 7->0, `char_idx`=0.
- `step` and `hold` asserted together for 5 cycles -> no change, no pulses; `load` and `step` in the same cycle -> load wins, `char_idx`=0.
- Force `limit`=3 while `char_idx`=9, one step -> wraps to 0 and `name_done`=1.
- With `CHAR_SEQ_PRESCALE_EN` and `PRESCALE`=4, `ena`=1 -> `char_strobe` every 4th cycle; `hold` for 2 cycles delays the next strobe by exactly 2.

Source files
------------

// File: rtl/char_sequencer_pkg.sv
// Shared widths and index types for the name sequencer, the length lookup and the glyph path.
package char_sequencer_pkg;
   localparam int NAME_W    = 3;
   localparam int CHAR_W    = 5;
   localparam int NUM_NAMES = 8;

   typedef logic [NAME_W-1:0] name_t;
   typedef logic [CHAR_W-1:0] char_t;

   // Name index is exactly NAME_W bits wide, so the natural overflow gives the mod-NUM_NAMES wrap
   function automatic name_t next_name(name_t n);
      return n + name_t'(1);
   endfunction
endpackage

// File: rtl/char_sequencer_if.sv
// Control/lookup bundle between the sequencer and its surroundings (controller, length lookup, glyph path).
interface char_sequencer_if;
   import char_sequencer_pkg::*;

   logic  ena;
   logic  step;
   logic  hold;
   logic  load;
   name_t name_sel;
   char_t limit;
   name_t name;
   char_t char_idx;
   logic  char_strobe;
   logic  name_done;

   modport master (output ena, step, hold, load, name_sel, limit,
                   input  name, char_idx, char_strobe, name_done);
   modport slave  (input  ena, step, hold, load, name_sel, limit,
                   output name, char_idx, char_strobe, name_done);
endinterface

// File: rtl/char_sequencer_step_prescaler.sv
// Free-running step prescaler: counts 0..PRESCALE-1 while enabled and emits one tick on the terminal count.
module step_prescaler #(
   parameter int unsigned PRESCALE = 1000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);
   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [CNT_W-1:0] TC = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt;

   assign tick = en & (cnt == TC);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en)
         cnt <= tick ? '0 : cnt + CNT_W'(1);
   end
endmodule

// File: rtl/char_sequencer.sv
// Name/character sequencer feeding the glyph path; define CHAR_SEQ_PRESCALE_EN to derive steps
// from an internal PRESCALE-cycle prescaler instead of the external step strobe.
module char_sequencer
   import char_sequencer_pkg::*;
#(
   parameter int unsigned PRESCALE = 1000
) (
   input logic             clk,
   input logic             rst_n,
   char_sequencer_if.slave bus
);
   logic  tick;
   logic  adv;
   logic  wrap;
   name_t name_q;
   char_t char_q;
   logic  strobe_q;
   logic  done_q;

`ifdef CHAR_SEQ_PRESCALE_EN
   step_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk  (clk),
      .rst_n(rst_n),
      .en   (bus.ena & ~bus.hold),
      .clr  (bus.ena & bus.load),
      .tick (tick)
   );
   logic unused_step;
   assign unused_step = bus.step;
`else
   assign tick = bus.step;
   logic [31:0] unused_prescale;
   assign unused_prescale = 32'(PRESCALE);
`endif

   assign adv  = bus.ena & ~bus.hold & ~bus.load & tick;
   // >= rather than == so a limit that shrinks under the current index still wraps cleanly
   assign wrap = (char_q >= bus.limit);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         name_q   <= '0;
         char_q   <= '0;
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
      end else if (bus.ena && bus.load) begin
         name_q   <= bus.name_sel;
         char_q   <= '0;
         strobe_q <= 1'b1;
         done_q   <= 1'b0;
      end else if (adv) begin
         if (wrap) begin
            char_q <= '0;
            name_q <= next_name(name_q);
         end else begin
            char_q <= char_q + char_t'(1);
         end
         strobe_q <= 1'b1;
         done_q   <= wrap;
      end else begin
         strobe_q <= 1'b0;
         done_q   <= 1'b0;
      end
   end

   assign bus.name        = name_q;
   assign bus.char_idx    = char_q;
   assign bus.char_strobe = strobe_q;
   assign bus.name_done   = done_q;
endmodule
